circuit2_result_collector: RTL and testbench

Downstream consumer of the `circuit2` datapath. It takes the registered `x`/`z` result pairs, one per accepted beat, and reduces each window of `WINDOW` pairs to four values: signed sum and floor-mean of `x`, and max/min of `z`. Each window result is presented on a valid/ready output port. The block back-pressures the producer while a result is pending and counts any beats offered while it is not ready.

---
 rtl/circuit2_pkg.sv | 16 +
 rtl/circuit2_result_collector_if.sv | 37 +++
 rtl/circuit2_minmax.sv | 52 +++++
 rtl/circuit2_result_collector.sv | 125 ++++++++++++
 tb/tb_circuit2_result_collector.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/circuit2_pkg.sv
// circuit2_pkg
// Shared types and constants for the circuit2 result collector slice.
//   col_state_t       : collector FSM state (ACCUM gathers beats, HOLD presents a result)
//   DROP_W            : width of the saturating dropped-beat counter
//   DEFAULT_DATAWIDTH : default width of the x/z result words
package circuit2_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } col_state_t;

  localparam int DROP_W            = 16;
  localparam int DEFAULT_DATAWIDTH = 32;

endpackage

// File: rtl/circuit2_result_collector_if.sv
// circuit2_result_collector_if
// Bundles the producer-side beat handshake, the synchronous clear and the
// window-result handshake of the collector.
//   master : producer/consumer side (drives x_in, z_in, in_valid, clear, out_ready)
//   slave  : collector side (drives in_ready, out_valid, sum_x, mean_x, max_z, min_z, drop_cnt)
interface circuit2_result_collector_if
  import circuit2_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int WINDOW    = 8
);
  localparam int SUMWIDTH = DATAWIDTH + $clog2(WINDOW);

  logic [DATAWIDTH-1:0] x_in;
  logic [DATAWIDTH-1:0] z_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [SUMWIDTH-1:0]  sum_x;
  logic [DATAWIDTH-1:0] mean_x;
  logic [DATAWIDTH-1:0] max_z;
  logic [DATAWIDTH-1:0] min_z;
  logic [DROP_W-1:0]    drop_cnt;

  modport master (
    output x_in, z_in, in_valid, clear, out_ready,
    input  in_ready, out_valid, sum_x, mean_x, max_z, min_z, drop_cnt
  );

  modport slave (
    input  x_in, z_in, in_valid, clear, out_ready,
    output in_ready, out_valid, sum_x, mean_x, max_z, min_z, drop_cnt
  );

endinterface

// File: rtl/circuit2_minmax.sv
// circuit2_minmax
// Running signed maximum/minimum of z over a window.
//   clk, rst_n         : clock, async active-low reset
//   clr_i              : synchronous clear of both registers (wins over load/update)
//   load_i             : first sample of a window, z_i loads both registers
//   update_i           : later sample, registers follow signed compare (ties keep held value)
//   z_i                : incoming signed sample
//   max_nxt_o/min_nxt_o: values including the current sample, used to capture the window result
module circuit2_minmax
  import circuit2_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        load_i,
  input  logic                        update_i,
  input  logic signed [DATAWIDTH-1:0] z_i,
  output logic signed [DATAWIDTH-1:0] max_nxt_o,
  output logic signed [DATAWIDTH-1:0] min_nxt_o
);

  logic signed [DATAWIDTH-1:0] max_q;
  logic signed [DATAWIDTH-1:0] min_q;

  always_comb begin
    max_nxt_o = max_q;
    min_nxt_o = min_q;
    if (load_i) begin
      max_nxt_o = z_i;
      min_nxt_o = z_i;
    end else if (update_i) begin
      if (z_i > max_q) max_nxt_o = z_i;
      if (z_i < min_q) min_nxt_o = z_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
    end else if (clr_i) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_nxt_o;
      min_q <= min_nxt_o;
    end
  end

endmodule

// File: rtl/circuit2_result_collector.sv
// circuit2_result_collector
// Reduces each window of WINDOW accepted x/z pairs to sum(x), floor-mean(x),
// max(z) and min(z), presented on a valid/ready port. Back-pressures the
// producer while a result is pending and counts beats offered meanwhile.
//   clk : clock, rising edge
//   rst : async active-low reset
//   bus : collector-side handshake bundle (slave modport)
//
// state | meaning
// ACCUM | in_ready high, accumulating beats of the current window
// HOLD  | result presented with out_valid high, producer stalled
module circuit2_result_collector
  import circuit2_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int WINDOW    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  circuit2_result_collector_if.slave    bus
);

  localparam int LOG_W    = $clog2(WINDOW);
  localparam int SUMWIDTH = DATAWIDTH + LOG_W;

  col_state_t                  state_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [LOG_W-1:0]            cnt_q;
  logic signed [SUMWIDTH-1:0]  acc_sum_q;
  logic signed [SUMWIDTH-1:0]  acc_sum_d;
  logic signed [DATAWIDTH-1:0] mean_d;
  logic signed [SUMWIDTH-1:0]  sum_x_q;
  logic signed [DATAWIDTH-1:0] mean_q;
  logic signed [DATAWIDTH-1:0] max_q;
  logic signed [DATAWIDTH-1:0] min_q;
  logic [DROP_W-1:0]           drop_q;
  logic signed [DATAWIDTH-1:0] max_nxt;
  logic signed [DATAWIDTH-1:0] min_nxt;
  logic                        accept;
  logic                        last;

  assign accept    = bus.in_valid && in_ready_q;
  assign last      = accept && (cnt_q == LOG_W'(WINDOW - 1));
  assign acc_sum_d = acc_sum_q + SUMWIDTH'($signed(bus.x_in));
  // SUMWIDTH - LOG_W == DATAWIDTH, so the shifted sum always fits mean_x.
  assign mean_d    = DATAWIDTH'(acc_sum_d >>> LOG_W);

  circuit2_minmax #(
    .DATAWIDTH (DATAWIDTH)
  ) u_minmax (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (bus.clear || last),
    .load_i    (accept && (cnt_q == '0)),
    .update_i  (accept && (cnt_q != '0)),
    .z_i       (bus.z_in),
    .max_nxt_o (max_nxt),
    .min_nxt_o (min_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_sum_q   <= '0;
      sum_x_q     <= '0;
      mean_q      <= '0;
      max_q       <= '0;
      min_q       <= '0;
      drop_q      <= '0;
    end else if (bus.clear) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_sum_q   <= '0;
      drop_q      <= '0;
    end else begin
      if (bus.in_valid && !in_ready_q && (drop_q != '1))
        drop_q <= drop_q + DROP_W'(1);
      case (state_q)
        ACCUM: begin
          // in_ready comes up one edge after reset release even with no beat.
          in_ready_q <= 1'b1;
          if (accept) begin
            if (last) begin
              sum_x_q     <= acc_sum_d;
              mean_q      <= mean_d;
              max_q       <= max_nxt;
              min_q       <= min_nxt;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
              cnt_q       <= '0;
              acc_sum_q   <= '0;
            end else begin
              cnt_q     <= cnt_q + LOG_W'(1);
              acc_sum_q <= acc_sum_d;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_x     = sum_x_q;
  assign bus.mean_x    = mean_q;
  assign bus.max_z     = max_q;
  assign bus.min_z     = min_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_circuit2_result_collector.sv
// tb_circuit2_result_collector
// Directed bench for the result collector with WINDOW=4, DATAWIDTH=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_circuit2_result_collector;

  localparam int DW  = 32;
  localparam int WIN = 4;

  logic clk;
  logic rst_n;

  circuit2_result_collector_if #(.DATAWIDTH(DW), .WINDOW(WIN)) bus();

  circuit2_result_collector #(
    .DATAWIDTH (DW),
    .WINDOW    (WIN)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0][31:0] x;
    logic [3:0][31:0] z;
    logic [33:0]      e_sum;
    logic [31:0]      e_mean;
    logic [31:0]      e_max;
    logic [31:0]      e_min;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input logic [31:0] x0, x1, x2, x3,
                              input logic [31:0] z0, z1, z2, z3,
                              input logic [33:0] s,
                              input logic [31:0] m, mx, mn);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.z[0] = z0; v.z[1] = z1; v.z[2] = z2; v.z[3] = z3;
    v.e_sum = s; v.e_mean = m; v.e_max = mx; v.e_min = mn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] x, input logic [31:0] z);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_beat: in_ready stuck at %0b, required 1", bus.in_ready);
    end
    bus.x_in     = x;
    bus.z_in     = z;
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_window(input string tag, input logic [33:0] s, input logic [31:0] m,
                              input logic [31:0] mx, input logic [31:0] mn);
    bus.in_valid = 1'b0;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(0));
    chk({tag, ".sum_x"},     64'(bus.sum_x),     64'(s));
    chk({tag, ".mean_x"},    64'(bus.mean_x),    64'(m));
    chk({tag, ".max_z"},     64'(bus.max_z),     64'(mx));
    chk({tag, ".min_z"},     64'(bus.min_z),     64'(mn));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".hs_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".hs_in_ready"},  64'(bus.in_ready),  64'(1));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    for (int b = 0; b < 4; b++) send_beat(v.x[b], v.z[b]);
    check_window(tag, v.e_sum, v.e_mean, v.e_max, v.e_min);
    handshake(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(0));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".sum_x"},     64'(bus.sum_x),     64'(0));
    chk({tag, ".mean_x"},    64'(bus.mean_x),    64'(0));
    chk({tag, ".max_z"},     64'(bus.max_z),     64'(0));
    chk({tag, ".min_z"},     64'(bus.min_z),     64'(0));
    chk({tag, ".drop_cnt"},  64'(bus.drop_cnt),  64'(0));
  endtask

  initial begin
    vecs[0] = mk(1, 2, 3, 4, 5, -3, 7, 0, 34'd10, 2, 7, -3);
    vecs[1] = mk(-1, -1, -1, 0, 0, 0, 0, 0, 34'(-3), -1, 0, 0);
    vecs[2] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                 32'h7FFFFFFF, 32'h80000000, 1, -1,
                 34'h1_FFFF_FFFC, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000);
    vecs[3] = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                 -5, -5, -9, -2, 34'h2_0000_0000, 32'h80000000, -2, -9);
    vecs[4] = mk(5, -6, 10, -3, 3, 3, 3, 3, 34'd6, 1, 3, 3);

    rst_n         = 1'b0;
    bus.x_in      = '0;
    bus.z_in      = '0;
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    chk("rel.in_ready_before_edge", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    chk("rel.in_ready_after_edge", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    chk("table.drop_cnt", 64'(bus.drop_cnt), 64'(0));

    // Backpressure: 10 cycles stalled in HOLD with beats offered.
    for (int b = 0; b < 4; b++) send_beat(1, b + 1);
    check_window("bp", 34'd4, 1, 4, 1);
    bus.in_valid = 1'b1;
    bus.x_in     = 1000;
    bus.z_in     = 1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp.stall_out_valid", 64'(bus.out_valid), 64'(1));
      chk("bp.stall_sum_x",     64'(bus.sum_x),     64'(4));
      chk("bp.stall_in_ready",  64'(bus.in_ready),  64'(0));
    end
    chk("bp.drop_cnt", 64'(bus.drop_cnt), 64'(10));
    bus.in_valid = 1'b0;
    handshake("bp");
    for (int b = 0; b < 4; b++) send_beat(2, 2);
    check_window("bp_next", 34'd8, 2, 2, 2);
    handshake("bp_next");
    chk("bp_next.drop_cnt", 64'(bus.drop_cnt), 64'(10));

    // Reset mid-window discards the partial window.
    send_beat(100, 100);
    send_beat(100, 100);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_beat(1, -1);
    send_beat(2, -4);
    send_beat(3, 6);
    send_beat(-2, 2);
    check_window("post_rst", 34'd4, 1, 6, -4);
    handshake("post_rst");

    // Clear mid-window restarts accumulation.
    send_beat(50, 99);
    send_beat(50, 99);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clr_mid.in_ready",  64'(bus.in_ready),  64'(1));
    chk("clr_mid.out_valid", 64'(bus.out_valid), 64'(0));
    for (int b = 0; b < 4; b++) send_beat(4, 9);
    check_window("clr_mid", 34'd16, 4, 9, 9);
    handshake("clr_mid");

    // Continuous stream with out_ready high: one drop per window.
    bus.out_ready = 1'b1;
    bus.x_in      = 3;
    bus.z_in      = 3;
    bus.in_valid  = 1'b1;
    repeat (10) @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream.drop_cnt",  64'(bus.drop_cnt),  64'(2));
    chk("stream.out_valid", 64'(bus.out_valid), 64'(0));
    chk("stream.in_ready",  64'(bus.in_ready),  64'(1));
    chk("stream.sum_x",     64'(bus.sum_x),     64'(12));

    // Saturation, then clear together with out_ready in HOLD.
    for (int b = 0; b < 4; b++) send_beat(3, 3);
    check_window("sat", 34'd12, 3, 3, 3);
    bus.in_valid = 1'b1;
    repeat (70000) @(negedge clk);
    chk("sat.drop_cnt",  64'(bus.drop_cnt),  64'(16'hFFFF));
    chk("sat.out_valid", 64'(bus.out_valid), 64'(1));
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    chk("clr_hold.drop_cnt",  64'(bus.drop_cnt),  64'(0));
    chk("clr_hold.out_valid", 64'(bus.out_valid), 64'(0));
    chk("clr_hold.in_ready",  64'(bus.in_ready),  64'(1));
    run_vec("after_clr", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
